move_arbiter: RTL and testbench
===============================

Name: move_arbiter

Overview:
- Sequences every change to the active brick for the playing-state FSM: moves, rotations, gravity falls and hard drops.
- Picks one pending event from event_controller and acknowledges it. Drives the shared collision_check with a trial position, rotation and type. Reports commit or reject.
- Applies rotation wall-kicks and lock delay. Hands placement off to the board FSM (place / clear / spawn / gameover).

Parameters:
- LOCK_FALLS, 2, number of consecutive collided FALL/DOWN attempts before a lock-place is requested (range 1..7).
- KICK_EN, 1, when 1 a rejected rotation retries at x+1, then at x-1.

Ports:
- main_clk  in  1  system game clock.
- rst_1plus  in  1  reset, asynchronous, active-high.
- enable  in  1  high while playing; low means no new op is started.
- event_out  in  `EVENT_LEN  pending events from event_controller.
- event_received  out  `EVENT_LEN  one-hot, one-cycle acknowledge back to event_controller.
- cur_pos  in  `POS_LEN  committed brick position.
- cur_dir  in  `DIR_LEN  committed rotation.
- cur_type  in  `BRICK_LEN  committed brick type.
- try_pos  out  `POS_LEN  trial position to collision_check.
- try_dir  out  `DIR_LEN  trial rotation.
- try_type  out  `BRICK_LEN  trial type.
- is_collided  in  1  combinational collision_check result on try_*.
- commit  out  1  one-cycle pulse; owner loads cur_* <= try_* on this cycle.
- place_req  out  1  level; the brick must be placed at its drop position.
- place_ack  in  1  one-cycle pulse from owner when place/clear/spawn is done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, lock_cnt 0, state IDLE. Reset asserted mid-operation aborts the op; there is no commit and no acknowledge.
- IDLE:
  - Waits for enable=1 and a nonzero event_out.
  - Priority is UP > DOWN > RIGHT > LEFT > SPACE > FALL.
  - The chosen event bit is set in event_received for exactly one cycle. Lower-priority pending bits are not acknowledged and stay pending.
  - try_* is loaded from cur_* with one change:
    - UP: dir+1, wraps modulo 2^DIR_LEN.
    - DOWN/FALL: y-1.
    - RIGHT: x+1.
    - LEFT: x-1.
  - LEFT at x=0 or DOWN/FALL at y=0 is treated as pre-collided; no wrap is issued.
    - LEFT goes to DONE_REJ.
    - DOWN/FALL goes straight to the lock-count path.
  - SPACE goes to PLACE.
  - Other ops go to CHECK.
- CHECK: samples is_collided, which is valid this cycle.
  - Not collided: set commit and go to DONE. A DOWN/FALL also clears lock_cnt.
  - Collided UP with KICK_EN=1: try_pos x+1, go to KICK_R.
  - Collided DOWN/FALL: lock_cnt+1. If the new value is >= LOCK_FALLS, go to PLACE; otherwise go to DONE_REJ.
  - Any other collision: go to DONE_REJ.
- KICK_R:
  - Not collided: commit, go to DONE.
  - Collided: if the original x is 0, go to DONE_REJ; otherwise set try_pos x = original x-1 and go to KICK_L.
- KICK_L: not collided commits and goes to DONE; collided goes to DONE_REJ.
- DONE / DONE_REJ: one settle cycle, during which commit is high in DONE. Next state is IDLE. This guarantees cur_* is updated before the next IDLE sample.
- PLACE:
  - place_req is held high until place_ack is seen. lock_cnt is then cleared and the state returns to IDLE.
  - Events are neither sampled nor acknowledged in PLACE.
  - place_ack outside PLACE is ignored.
- Latency: event sampled in cycle T; ack and try_* valid at T+1; commit at T+2; next op sampled no earlier than T+3. A kicked rotation adds 1–2 cycles.
- enable dropping mid-op: the current op completes, including PLACE. enable only gates new ops in IDLE.
- A successful UP/LEFT/RIGHT does not clear lock_cnt; only a successful fall clears it.

Decomposition:
- Shared header.v carries:
  - the existing EVENT_* bit indices and GETX/GETY/MAKE_POS macros;
  - new `OP_LEN and `OP_NONE/ROT/DOWN/RIGHT/LEFT/DROP/FALL op codes;
  - `LOCK_CNT_LEN (3).
- Sub-module event_pick: combinational priority encoder from event_out to op code plus one-hot ack mask.

Test Plan:
- cur_pos=(6,10), event_out=RIGHT, is_collided=0 -> event_received RIGHT at T+1, try_pos=(7,10), commit pulse at T+2, busy low at T+3.
- event_out=UP|LEFT simultaneously -> only the UP ack; LEFT is acked in the next op, no earlier than T+3.
- UP with is_collided=1,1,0 across CHECK/KICK_R/KICK_L, cur_pos=(6,10) -> try_pos sequence (6,10),(7,10),(5,10); commit with try_pos=(5,10) and dir+1.
- LOCK_FALLS=2, FALL collided twice -> first goes to DONE_REJ with no place_req; second raises place_req. Hold place_ack low 5 cycles -> place_req stays high. Pulse place_ack -> IDLE, lock_cnt=0.
- LEFT at x=0 -> ack, no commit, no collision sample needed. FALL at y=0 -> lock count increments.
- Assert rst_1plus during CHECK -> all outputs 0 immediately. Assert enable=0 with pending events -> no ack.

Source files
------------

// File: rtl/move_arbiter_pkg.sv
// Shared widths, event bit indices, op codes and position helpers for the
// active-brick move arbiter.
package move_arbiter_pkg;

    localparam int EVENT_LEN    = 6;
    localparam int X_LEN        = 4;
    localparam int Y_LEN        = 5;
    localparam int POS_LEN      = X_LEN + Y_LEN;
    localparam int DIR_LEN      = 2;
    localparam int BRICK_LEN    = 3;
    localparam int LOCK_CNT_LEN = 3;

    localparam int EVENT_UP    = 0;
    localparam int EVENT_DOWN  = 1;
    localparam int EVENT_LEFT  = 2;
    localparam int EVENT_RIGHT = 3;
    localparam int EVENT_SPACE = 4;
    localparam int EVENT_FALL  = 5;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ROT,
        OP_DOWN,
        OP_RIGHT,
        OP_LEFT,
        OP_DROP,
        OP_FALL
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_KICK_R,
        ST_KICK_L,
        ST_DONE,
        ST_DONE_REJ,
        ST_PLACE
    } state_t;

    // Position layout is {x, y}.
    function automatic logic [X_LEN-1:0] get_x(input logic [POS_LEN-1:0] pos);
        return pos[POS_LEN-1:Y_LEN];
    endfunction

    function automatic logic [Y_LEN-1:0] get_y(input logic [POS_LEN-1:0] pos);
        return pos[Y_LEN-1:0];
    endfunction

    function automatic logic [POS_LEN-1:0] make_pos(input logic [X_LEN-1:0] x,
                                                    input logic [Y_LEN-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/move_arbiter_event_pick.sv
// Fixed-priority pick of one pending event: UP > DOWN > RIGHT > LEFT > SPACE > FALL.
module move_arbiter_event_pick
    import move_arbiter_pkg::*;
(
    input  logic [EVENT_LEN-1:0] event_i,
    output op_t                  op_o,
    output logic [EVENT_LEN-1:0] ack_mask_o
);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        op_o       = OP_NONE;
        ack_mask_o = '0;
        if (event_i[EVENT_UP]) begin
            op_o                 = OP_ROT;
            ack_mask_o[EVENT_UP] = 1'b1;
        end else if (event_i[EVENT_DOWN]) begin
            op_o                   = OP_DOWN;
            ack_mask_o[EVENT_DOWN] = 1'b1;
        end else if (event_i[EVENT_RIGHT]) begin
            op_o                    = OP_RIGHT;
            ack_mask_o[EVENT_RIGHT] = 1'b1;
        end else if (event_i[EVENT_LEFT]) begin
            op_o                   = OP_LEFT;
            ack_mask_o[EVENT_LEFT] = 1'b1;
        end else if (event_i[EVENT_SPACE]) begin
            op_o                    = OP_DROP;
            ack_mask_o[EVENT_SPACE] = 1'b1;
        end else if (event_i[EVENT_FALL]) begin
            op_o                   = OP_FALL;
            ack_mask_o[EVENT_FALL] = 1'b1;
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Sequences moves, rotations, falls and drops of the active brick through the
// shared collision checker, with wall-kicks, lock delay and placement handoff.
module move_arbiter
    import move_arbiter_pkg::*;
#(
    parameter int LOCK_FALLS = 2,
    parameter int KICK_EN    = 1
) (
    input  logic                 main_clk,
    input  logic                 rst_1plus,
    input  logic                 enable,
    input  logic [EVENT_LEN-1:0] event_out,
    output logic [EVENT_LEN-1:0] event_received,
    input  logic [POS_LEN-1:0]   cur_pos,
    input  logic [DIR_LEN-1:0]   cur_dir,
    input  logic [BRICK_LEN-1:0] cur_type,
    output logic [POS_LEN-1:0]   try_pos,
    output logic [DIR_LEN-1:0]   try_dir,
    output logic [BRICK_LEN-1:0] try_type,
    input  logic                 is_collided,
    output logic                 commit,
    output logic                 place_req,
    input  logic                 place_ack,
    output logic                 busy
);

    localparam logic [LOCK_CNT_LEN-1:0] LOCK_LIMIT = LOCK_CNT_LEN'(LOCK_FALLS);

    state_t                  state_q, state_d, lock_next;
    op_t                     op_q, op_d, pick_op;
    logic [EVENT_LEN-1:0]    pick_mask, ack_q, ack_d;
    logic [LOCK_CNT_LEN-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
    logic [X_LEN-1:0]        orig_x_q, orig_x_d, cur_x;
    logic [Y_LEN-1:0]        cur_y, try_y;
    logic [POS_LEN-1:0]      try_pos_q, try_pos_d;
    logic [DIR_LEN-1:0]      try_dir_q, try_dir_d;
    logic [BRICK_LEN-1:0]    try_type_q, try_type_d;
    logic                    commit_q, commit_d;
    logic                    place_req_q, busy_q;
    logic                    is_fall;

    move_arbiter_event_pick u_pick (
        .event_i    (event_out),
        .op_o       (pick_op),
        .ack_mask_o (pick_mask)
    );

    assign cur_x     = get_x(cur_pos);
    assign cur_y     = get_y(cur_pos);
    assign try_y     = get_y(try_pos_q);
    assign is_fall   = (op_q == OP_DOWN) || (op_q == OP_FALL);
    // A blocked fall either exhausts the lock delay or is simply rejected.
    assign lock_inc  = lock_cnt_q + 1'b1;
    assign lock_next = (lock_inc >= LOCK_LIMIT) ? ST_PLACE : ST_DONE_REJ;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lock_cnt_d = lock_cnt_q;
        orig_x_d   = orig_x_q;
        try_pos_d  = try_pos_q;
        try_dir_d  = try_dir_q;
        try_type_d = try_type_q;
        ack_d      = '0;
        commit_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && (pick_op != OP_NONE)) begin
                    ack_d      = pick_mask;
                    op_d       = pick_op;
                    orig_x_d   = cur_x;
                    try_pos_d  = cur_pos;
                    try_dir_d  = cur_dir;
                    try_type_d = cur_type;
                    state_d    = ST_CHECK;
                    unique case (pick_op)
                        OP_ROT:   try_dir_d = cur_dir + 1'b1;
                        OP_RIGHT: try_pos_d = make_pos(cur_x + 1'b1, cur_y);
                        OP_DROP:  state_d   = ST_PLACE;
                        OP_LEFT: begin
                            if (cur_x == '0) state_d = ST_DONE_REJ;
                            else             try_pos_d = make_pos(cur_x - 1'b1, cur_y);
                        end
                        OP_DOWN, OP_FALL: begin
                            // Floor row: counts as a collided fall without probing.
                            if (cur_y == '0) begin
                                lock_cnt_d = lock_inc;
                                state_d    = lock_next;
                            end else begin
                                try_pos_d = make_pos(cur_x, cur_y - 1'b1);
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_CHECK: begin
                if (!is_collided) begin
                    commit_d = 1'b1;
                    state_d  = ST_DONE;
                    if (is_fall) lock_cnt_d = '0;
                end else if ((op_q == OP_ROT) && (KICK_EN != 0)) begin
                    try_pos_d = make_pos(orig_x_q + 1'b1, try_y);
                    state_d   = ST_KICK_R;
                end else if (is_fall) begin
                    lock_cnt_d = lock_inc;
                    state_d    = lock_next;
                end else begin
                    state_d = ST_DONE_REJ;
                end
            end

            ST_KICK_R: begin
                if (!is_collided) begin
                    commit_d = 1'b1;
                    state_d  = ST_DONE;
                end else if (orig_x_q == '0) begin
                    state_d = ST_DONE_REJ;
                end else begin
                    try_pos_d = make_pos(orig_x_q - 1'b1, try_y);
                    state_d   = ST_KICK_L;
                end
            end

            ST_KICK_L: begin
                if (!is_collided) begin
                    commit_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_DONE_REJ;
                end
            end

            ST_DONE, ST_DONE_REJ: state_d = ST_IDLE;

            ST_PLACE: begin
                if (place_ack) begin
                    lock_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            lock_cnt_q  <= '0;
            orig_x_q    <= '0;
            try_pos_q   <= '0;
            try_dir_q   <= '0;
            try_type_q  <= '0;
            ack_q       <= '0;
            commit_q    <= 1'b0;
            place_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lock_cnt_q  <= lock_cnt_d;
            orig_x_q    <= orig_x_d;
            try_pos_q   <= try_pos_d;
            try_dir_q   <= try_dir_d;
            try_type_q  <= try_type_d;
            ack_q       <= ack_d;
            commit_q    <= commit_d;
            place_req_q <= (state_d == ST_PLACE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign event_received = ack_q;
    assign try_pos        = try_pos_q;
    assign try_dir        = try_dir_q;
    assign try_type       = try_type_q;
    assign commit         = commit_q;
    assign place_req      = place_req_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Randomized bench for move_arbiter: a bitmap board stands in for collision_check
// and an op-level model predicts ack, outcome, position and latency.
module tb_move_arbiter;
    import move_arbiter_pkg::*;

    localparam int LOCK_FALLS = 2;
    localparam int KICK_EN    = 1;
    localparam int K_REJ      = 0;
    localparam int K_COMMIT   = 1;
    localparam int K_PLACE    = 2;

    logic                 main_clk = 1'b0;
    logic                 rst_1plus, enable, is_collided, commit, place_req, place_ack, busy;
    logic [EVENT_LEN-1:0] event_out, event_received;
    logic [POS_LEN-1:0]   cur_pos, try_pos;
    logic [DIR_LEN-1:0]   cur_dir, try_dir;
    logic [BRICK_LEN-1:0] cur_type, try_type;
    logic [2047:0]        blocked;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int model_lc = 0;
    int last_ack_cyc = 0;
    int e_ack, e_kind, e_x, e_y, e_d, e_lat, e_lc, e_t1x, e_t1y, e_t1d;
    int trace_x [0:63];

    always #5 main_clk = ~main_clk;
    always @(posedge main_clk) cyc <= cyc + 1;

    // Board occupancy indexed by {dir, x, y}.
    assign is_collided = blocked[{try_dir, try_pos}];

    move_arbiter #(.LOCK_FALLS(LOCK_FALLS), .KICK_EN(KICK_EN)) dut (
        .main_clk       (main_clk),
        .rst_1plus      (rst_1plus),
        .enable         (enable),
        .event_out      (event_out),
        .event_received (event_received),
        .cur_pos        (cur_pos),
        .cur_dir        (cur_dir),
        .cur_type       (cur_type),
        .try_pos        (try_pos),
        .try_dir        (try_dir),
        .try_type       (try_type),
        .is_collided    (is_collided),
        .commit         (commit),
        .place_req      (place_req),
        .place_ack      (place_ack),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit blk(input int x, input int y, input int d);
        return blocked[(d % 4) * 512 + (x % 16) * 32 + (y % 32)];
    endfunction

    function automatic void set_blk(input int x, input int y, input int d);
        blocked[(d % 4) * 512 + (x % 16) * 32 + (y % 32)] = 1'b1;
    endfunction

    task automatic set_cur(input int x, input int y, input int d, input int t);
        cur_pos  = {X_LEN'(x), Y_LEN'(y)};
        cur_dir  = DIR_LEN'(d);
        cur_type = BRICK_LEN'(t);
    endtask

    // Op-level prediction from the game rules, given the current pending set.
    task automatic predict();
        int x = int'(cur_pos[POS_LEN-1:Y_LEN]);
        int y = int'(cur_pos[Y_LEN-1:0]);
        int d = int'(cur_dir);
        int order [6] = '{EVENT_UP, EVENT_DOWN, EVENT_RIGHT, EVENT_LEFT, EVENT_SPACE, EVENT_FALL};
        int chosen = -1;
        int nd;
        for (int i = 5; i >= 0; i--) if (event_out[order[i]]) chosen = order[i];
        e_ack = 1 << chosen;
        e_x = x; e_y = y; e_d = d; e_lc = model_lc;
        e_t1x = x; e_t1y = y; e_t1d = d;
        e_kind = K_REJ; e_lat = 3;
        case (chosen)
            EVENT_UP: begin
                nd = (d + 1) % 4;
                e_t1d = nd; e_d = nd;
                if (!blk(x, y, nd)) begin e_kind = K_COMMIT; e_lat = 2; end
                else if (KICK_EN == 0) begin e_kind = K_REJ; e_lat = 3; end
                else if (!blk((x + 1) % 16, y, nd)) begin e_kind = K_COMMIT; e_x = (x + 1) % 16; e_lat = 3; end
                else if (x == 0) begin e_kind = K_REJ; e_lat = 4; end
                else if (!blk(x - 1, y, nd)) begin e_kind = K_COMMIT; e_x = x - 1; e_lat = 4; end
                else begin e_kind = K_REJ; e_lat = 5; end
            end
            EVENT_DOWN, EVENT_FALL: begin
                if (y != 0) e_t1y = y - 1;
                if (y == 0 || blk(x, y - 1, d)) begin
                    e_lc = model_lc + 1;
                    if (e_lc >= LOCK_FALLS) begin e_kind = K_PLACE; e_lat = (y == 0) ? 1 : 2; e_lc = 0; end
                    else begin e_kind = K_REJ; e_lat = (y == 0) ? 2 : 3; end
                end else begin
                    e_kind = K_COMMIT; e_y = y - 1; e_lat = 2; e_lc = 0;
                end
            end
            EVENT_RIGHT: begin
                e_t1x = (x + 1) % 16;
                if (blk(e_t1x, y, d)) begin e_kind = K_REJ; e_lat = 3; end
                else begin e_kind = K_COMMIT; e_x = e_t1x; e_lat = 2; end
            end
            EVENT_LEFT: begin
                if (x == 0) begin e_kind = K_REJ; e_lat = 2; end
                else begin
                    e_t1x = x - 1;
                    if (blk(e_t1x, y, d)) begin e_kind = K_REJ; e_lat = 3; end
                    else begin e_kind = K_COMMIT; e_x = e_t1x; e_lat = 2; end
                end
            end
            default: begin e_kind = K_PLACE; e_lat = 1; e_lc = 0; end
        endcase
    endtask

    // Runs one op from IDLE with events already pending; acts as event_controller
    // (clears acked bits) and as owner (loads cur_* on commit, answers place_req).
    task automatic run_op(input bit drop_en, input int hold, input bit stray);
        logic [31:0]          ack_val = '0;
        int                   ack_cnt = 0, ack_k = -1, commit_cnt = 0, commit_k = -1;
        int                   place_k = -1, end_k = -1;
        logic [POS_LEN-1:0]   c_pos = '0;
        logic [DIR_LEN-1:0]   c_dir = '0;
        logic [BRICK_LEN-1:0] c_type = '0;
        logic [BRICK_LEN-1:0] exp_type;
        bit                   held_ok = 1'b1;
        exp_type = cur_type;
        predict();
        enable = 1'b1;
        for (int k = 1; k <= 40 && end_k < 0; k++) begin
            @(negedge main_clk);
            place_ack = 1'b0;
            if (drop_en && k == 1) enable = 1'b0;
            trace_x[k] = int'(try_pos[POS_LEN-1:Y_LEN]);
            if (k == 1) begin
                check("trial_x", try_pos[POS_LEN-1:Y_LEN], e_t1x);
                check("trial_y", try_pos[Y_LEN-1:0], e_t1y);
                check("trial_dir", try_dir, e_t1d);
            end
            if (event_received != '0) begin
                ack_cnt++;
                if (ack_k < 0) begin ack_k = k; ack_val = event_received; last_ack_cyc = cyc; end
                event_out = event_out & ~event_received;
            end
            if (commit) begin
                commit_cnt++; commit_k = k;
                c_pos = try_pos; c_dir = try_dir; c_type = try_type;
                cur_pos = try_pos; cur_dir = try_dir;
            end
            if (place_req && place_k < 0) begin
                place_k = k;
                repeat (hold) begin
                    @(negedge main_clk);
                    if (!place_req) held_ok = 1'b0;
                end
                place_ack = 1'b1;
                @(negedge main_clk);
                place_ack = 1'b0;
                check("place_release", {place_req, busy}, 0);
                end_k = k;
            end else if (!busy) begin
                end_k = k;
            end
            if (stray && k == 1 && e_kind != K_PLACE) place_ack = 1'b1;
        end
        if (end_k < 0) check("op_timeout", 1, 0);
        check("ack_value", ack_val, e_ack);
        check("ack_pulses", ack_cnt, 1);
        check("ack_latency", ack_k, 1);
        check("commit_pulses", commit_cnt, (e_kind == K_COMMIT));
        if (e_kind == K_COMMIT) begin
            check("commit_latency", commit_k, e_lat);
            check("commit_x", c_pos[POS_LEN-1:Y_LEN], e_x);
            check("commit_y", c_pos[Y_LEN-1:0], e_y);
            check("commit_dir", c_dir, e_d);
            check("commit_type", c_type, exp_type);
            check("idle_after_commit", end_k, commit_k + 1);
        end else if (e_kind == K_REJ) begin
            check("reject_no_place", place_k, -1);
            check("reject_end", end_k, e_lat);
        end else begin
            check("place_latency", place_k, e_lat);
            check("place_held", held_ok, 1);
        end
        model_lc = e_lc;
        enable = 1'b1;
    endtask

    initial begin
        int a1, c;
        rst_1plus = 1'b1; enable = 1'b0; place_ack = 1'b0;
        event_out = '0; blocked = '0;
        set_cur(6, 10, 0, 1);
        #1;
        check("reset_outputs", {event_received, try_pos, try_dir, try_type, commit, place_req, busy}, 0);
        repeat (2) @(negedge main_clk);
        rst_1plus = 1'b0;

        // Plain move right.
        event_out = 1 << EVENT_RIGHT;
        run_op(1'b0, 0, 1'b0);

        // Simultaneous UP and LEFT: UP first, LEFT stays pending.
        set_cur(6, 10, 0, 2);
        event_out = (1 << EVENT_UP) | (1 << EVENT_LEFT);
        run_op(1'b0, 0, 1'b0);
        a1 = last_ack_cyc;
        check("left_still_pending", event_out, 1 << EVENT_LEFT);
        run_op(1'b0, 0, 1'b0);
        check("next_op_gap", (last_ack_cyc - a1 >= 3), 1);

        // Rotation kicked twice: centre and right blocked, left free.
        set_cur(6, 10, 0, 3);
        set_blk(6, 10, 1); set_blk(7, 10, 1);
        event_out = 1 << EVENT_UP;
        run_op(1'b0, 0, 1'b0);
        check("kick_r_trial_x", trace_x[2], 7);
        check("kick_l_trial_x", trace_x[3], 5);

        // Lock delay: two blocked falls, long place handshake, then count is clear.
        blocked = '0;
        set_cur(3, 10, 0, 4);
        set_blk(3, 9, 0);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 0, 1'b0);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 5, 1'b0);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 0, 1'b0);
        check("lock_cleared_model", model_lc, 1);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 2, 1'b0);

        // Edges: LEFT at x=0 must not wrap; FALL at y=0 counts toward lock.
        blocked = '0;
        set_cur(0, 10, 0, 5);
        event_out = 1 << EVENT_LEFT; run_op(1'b0, 0, 1'b0);
        set_cur(4, 0, 0, 5);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 0, 1'b0);
        event_out = 1 << EVENT_FALL; run_op(1'b0, 1, 1'b0);

        // Disabled: pending events are left alone.
        enable = 1'b0;
        event_out = 1 << EVENT_RIGHT;
        c = 0;
        repeat (5) begin
            @(negedge main_clk);
            if (event_received != '0 || busy) c++;
        end
        check("disabled_no_ack", c, 0);
        run_op(1'b0, 0, 1'b0);

        // Reset while in CHECK aborts the op.
        set_cur(6, 10, 0, 1);
        event_out = 1 << EVENT_RIGHT;
        enable = 1'b1;
        @(negedge main_clk);
        check("mid_op_busy", busy, 1);
        rst_1plus = 1'b1;
        #1;
        check("reset_mid_op", {event_received, try_pos, try_dir, try_type, commit, place_req, busy}, 0);
        event_out = '0;
        @(negedge main_clk);
        rst_1plus = 1'b0;
        model_lc = 0;
        c = 0;
        repeat (3) begin
            @(negedge main_clk);
            c += int'(commit) + int'(busy);
        end
        check("no_commit_after_reset", c, 0);

        // Random ops on random boards.
        for (int i = 0; i < 300; i++) begin
            for (int w = 0; w < 64; w++)
                blocked[w*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom);
            set_cur(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15),
                    ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 31),
                    $urandom_range(0, 3), $urandom_range(0, 7));
            if (event_out == '0) event_out = EVENT_LEN'($urandom_range(1, 63));
            run_op($urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
